// File: rtl/mips_muldiv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : mips_muldiv_alu
//  Purpose  : MIPS EX-stage ALU. Single-cycle logic/arith/shift ops plus an
//             iterative multiply/divide unit (one bit per cycle) with HI/LO
//             registers and a start/busy/done handshake.
//  Config   : define ALU_MULDIV_EN to build the multiply/divide unit. When
//             undefined, codes 10..15 return 0 and busy/done/hi/lo are tied 0.
//  Ports    : clk, reset (sync, active-high), ALUCnt[3:0] op select,
//             input1/input2 operands, shamt shift amount, start launch pulse,
//             result/zero (combinational), busy, done (1-cycle pulse), hi, lo.
//  Revision : 1.0  initial release
// ============================================================================
module mips_muldiv_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUCnt,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shamt,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    always_comb begin
        w_result = '0;
        case (ALUCnt)
            4'd0:    w_result = input1 & input2;
            4'd1:    w_result = input1 | input2;
            4'd2:    w_result = input1 + input2;
            4'd3:    w_result = input1 ^ input2;
            4'd4:    w_result = ~(input1 | input2);
            4'd5:    w_result = input2 << shamt;
            4'd6:    w_result = input1 - input2;
            4'd7:    w_result = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            4'd8:    w_result = input2 >> shamt;
            4'd9:    w_result = $signed(input2) >>> shamt;
            4'd14:   w_result = w_hi;
            4'd15:   w_result = w_lo;
            default: w_result = '0;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == '0);
    assign hi     = w_hi;
    assign lo     = w_lo;

`ifdef ALU_MULDIV_EN
    localparam logic [1:0]     c_ST_IDLE = 2'd0;
    localparam logic [1:0]     c_ST_RUN  = 2'd1;
    localparam logic [1:0]     c_ST_FIX  = 2'd2;
    localparam logic [1:0]     c_ST_DONE = 2'd3;
    localparam logic [SHW-1:0] c_LAST    = SHW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;     // negate quotient / product
    logic             neg_r_q, neg_r_d;     // negate remainder
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] opb_q, opb_d;         // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_q, acc_d;         // product upper half / partial remainder
    logic [WIDTH-1:0] work_q, work_d;       // multiplier->product lower half / dividend->quotient
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             w_launch;
    logic             w_signed;
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [2*WIDTH-1:0] w_prod;

    // A new op may be accepted while idle or in the done cycle.
    assign w_launch = start && (ALUCnt >= 4'd10) && (ALUCnt <= 4'd13) &&
                      ((state_q == c_ST_IDLE) || (state_q == c_ST_DONE));
    assign w_signed = ALUCnt[0];
    assign w_a_neg  = w_signed && input1[WIDTH-1];
    assign w_b_neg  = w_signed && input2[WIDTH-1];
    assign w_a_mag  = w_a_neg ? (~input1 + 1'b1) : input1;
    assign w_b_mag  = w_b_neg ? (~input2 + 1'b1) : input2;

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the {carry, acc, work} chain right by one.
    assign w_sum   = work_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
    // Restoring divide step: the trial difference is negative exactly when
    // its top bit is set, since the shifted remainder is below twice the divisor.
    assign w_shift = {acc_q, work_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, opb_q};
    assign w_prod  = neg_q_q ? (~{acc_q, work_q} + 1'b1) : {acc_q, work_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_ST_IDLE;
            is_div_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            bzero_q    <= 1'b0;
            dividend_q <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            bzero_q    <= bzero_d;
            dividend_q <= dividend_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        bzero_d    = bzero_q;
        dividend_d = dividend_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            c_ST_RUN: begin
                if (is_div_q) begin
                    acc_d  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], ~w_trial[WIDTH]};
                end else begin
                    acc_d  = w_sum[WIDTH:1];
                    work_d = {w_sum[0], work_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                if (!is_div_q) begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = dividend_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_r_q ? (~acc_q + 1'b1) : acc_q;
                    lo_d = neg_q_q ? (~work_q + 1'b1) : work_q;
                end
                state_d = c_ST_DONE;
            end
            default: begin
                // IDLE and DONE both return to IDLE unless a new op launches.
                state_d = c_ST_IDLE;
            end
        endcase
        if (w_launch) begin
            state_d    = c_ST_RUN;
            is_div_d   = ALUCnt[2];
            neg_q_d    = w_a_neg ^ w_b_neg;
            neg_r_d    = w_a_neg;
            bzero_d    = (input2 == '0);
            dividend_d = input1;
            opb_d      = ALUCnt[2] ? w_b_mag : w_a_mag;
            work_d     = ALUCnt[2] ? w_a_mag : w_b_mag;
            acc_d      = '0;
            cnt_d      = c_LAST;
        end
    end

    always_comb begin
        busy = (state_q == c_ST_RUN) || (state_q == c_ST_FIX);
        done = (state_q == c_ST_DONE);
    end

    assign w_hi = hi_q;
    assign w_lo = lo_q;
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset, start};
    assign w_hi     = '0;
    assign w_lo     = '0;
    assign busy     = 1'b0;
    assign done     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_muldiv_alu
//  Purpose  : Self-checking bench for mips_muldiv_alu (WIDTH=32). Random and
//             directed combinational ops against a reference model; when
//             ALU_MULDIV_EN is defined, long ops are checked for latency,
//             operand latching, ignored starts and reset abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_muldiv_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ALUCnt;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic [4:0]    shamt;
    logic          start;
    logic [W-1:0]  result;
    logic          zero;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  m_hi  = '0;
    logic [W-1:0]  m_lo  = '0;

    mips_muldiv_alu #(.WIDTH(W), .SHW(5)) dut (
        .clk(clk), .reset(reset), .ALUCnt(ALUCnt), .input1(input1),
        .input2(input2), .shamt(shamt), .start(start), .result(result),
        .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] alu_ref(input int op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] sh);
        longint sb;
        sb = longint'($signed(b));
        case (op)
            0:  return a & b;
            1:  return a | b;
            2:  return a + b;
            3:  return a ^ b;
            4:  return ~(a | b);
            5:  return b << sh;
            6:  return a - b;
            7:  return (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
            8:  return b >> sh;
            9:  return W'(sb >>> sh);
`ifdef ALU_MULDIV_EN
            14: return m_hi;
            15: return m_lo;
`endif
            default: return '0;
        endcase
    endfunction

    // Reference long-op result from plain 64-bit arithmetic.
    task automatic long_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] rh, output logic [W-1:0] rl);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            10: p = {32'd0, a} * {32'd0, b};
            11: p = 64'(sa * sb);
            12: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: p = (b == 0) ? {a, 32'hFFFF_FFFF}
                                  : {W'(sa % sb), W'(sa / sb)};
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endtask

    task automatic comb_test(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [4:0] sh);
        logic [W-1:0] e;
        @(negedge clk);
        ALUCnt = 4'(op); input1 = a; input2 = b; shamt = sh; start = 1'b0;
        #1;
        e = alu_ref(op, a, b, sh);
        check($sformatf("res op%0d", op), 64'(result), 64'(e));
        check($sformatf("zero op%0d", op), 64'(zero), 64'(e == 0));
    endtask

`ifdef ALU_MULDIV_EN
    // intr: 0 none, 1 extra start at cycle T+5, 2 reset at cycle T+10.
    task automatic run_long(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int intr);
        logic [W-1:0] eh, el;
        long_ref(op, a, b, eh, el);
        @(negedge clk);
        ALUCnt = 4'(op); input1 = a; input2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ALUCnt = 4'd14; input1 = $urandom; input2 = $urandom;
        for (int j = 1; j <= W + 1; j++) begin
            if (j > 1) @(negedge clk);
            if (intr == 2 && j == 11) begin
                check("abort busy", 64'(busy), 64'd0);
                check("abort hi", 64'(hi), 64'd0);
                check("abort lo", 64'(lo), 64'd0);
                reset = 1'b0;
                m_hi = '0; m_lo = '0;
                for (int k = 0; k < W + 4; k++) begin
                    @(negedge clk);
                    check("abort no done", 64'(done), 64'd0);
                end
                return;
            end
            check($sformatf("busy T+%0d", j), 64'(busy), 64'd1);
            check($sformatf("done T+%0d", j), 64'(done), 64'd0);
            if (j == 1) check("stale mfhi", 64'(result), 64'(m_hi));
            if (intr == 1 && j == 5) begin
                start = 1'b1; ALUCnt = 4'd12; input1 = $urandom; input2 = 32'd3;
            end
            if (intr == 1 && j == 6) begin
                start = 1'b0; ALUCnt = 4'd14;
            end
            if (intr == 2 && j == 10) reset = 1'b1;
        end
        @(negedge clk);
        check("done pulse", 64'(done), 64'd1);
        check("busy in done", 64'(busy), 64'd0);
        check($sformatf("hi op%0d", op), 64'(hi), 64'(eh));
        check($sformatf("lo op%0d", op), 64'(lo), 64'(el));
        check("mfhi", 64'(result), 64'(eh));
        m_hi = eh; m_lo = el;
        ALUCnt = 4'd15;
        #1;
        check("mflo", 64'(result), 64'(el));
        @(negedge clk);
        check("done cleared", 64'(done), 64'd0);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; ALUCnt = 4'd0;
        input1 = '0; input2 = '0; shamt = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        reset = 1'b0;

        comb_test(2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        comb_test(6, 32'd5, 32'd5, 5'd0);
        comb_test(9, 32'd0, 32'h8000_0000, 5'd2);
        comb_test(8, 32'd0, 32'h8000_0000, 5'd2);
        comb_test(7, 32'hFFFF_FFFF, 32'd1, 5'd0);
        comb_test(7, 32'd1, 32'hFFFF_FFFF, 5'd0);
        comb_test(5, 32'd0, 32'h8000_0001, 5'd31);
        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(0, 15);
            comb_test(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                      5'($urandom));
        end

`ifdef ALU_MULDIV_EN
        run_long(11, 32'hFFFF_FFFD, 32'd7, 0);
        comb_test(15, $urandom, $urandom, 5'd0);
        run_long(13, 32'hFFFF_FFF9, 32'd2, 0);
        run_long(12, 32'd7, 32'd0, 0);
        run_long(13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_long(13, 32'hFFFF_FFF9, 32'd0, 0);
        run_long(10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_long(10, 32'h1234_5678, 32'h9ABC_DEF0, 2);
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] b;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            run_long(10 + $urandom_range(0, 3), $urandom, b, 0);
        end
`else
        @(negedge clk);
        ALUCnt = 4'd11; input1 = 32'hFFFF_FFFD; input2 = 32'd7; start = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            check("off busy", 64'(busy), 64'd0);
            check("off done", 64'(done), 64'd0);
        end
        start = 1'b0;
        comb_test(14, $urandom, $urandom, 5'd0);
        comb_test(15, $urandom, $urandom, 5'd0);
        check("off hi", 64'(hi), 64'd0);
        check("off lo", 64'(lo), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
